// File: rtl/vector_recorder_pkg.sv
// Shared types and default sizes for the vector recorder.
// rec_state_t is the recorder FSM state; VEC_* are the default vector geometry.
package vector_recorder_pkg;

   localparam int VEC_WIDTH = 5;
   localparam int VEC_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DUMP
   } rec_state_t;

endpackage

// File: rtl/vector_recorder_mem.sv
// WIDTH x DEPTH register file: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read). No reset.
module vector_recorder_mem
   import vector_recorder_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int DEPTH = VEC_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/vector_recorder.sv
// Capture buffer: records up to DEPTH vectors, then streams them out in order.
// Ports: clk, reset, start/stop, in_valid/in_vec, out_valid/out_ready/out_vec/out_last, count, busy.
module vector_recorder
   import vector_recorder_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int DEPTH = VEC_DEPTH,
   localparam int CW = $clog2(DEPTH+1),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_vec,
   output logic             out_last,
   output logic [CW-1:0]    count,
   output logic             busy
);

   rec_state_t       state;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_nxt;
   logic             wr_en;
   logic             last_beat;
   logic [WIDTH-1:0] rd_data;

   // count doubles as the write pointer; it never reaches DEPTH in CAPTURE.
   assign wr_en     = (state == CAPTURE) && in_valid;
   assign cnt_nxt   = count + CW'(wr_en);
   assign last_beat = (CW'(rd_ptr) == count - CW'(1));

   vector_recorder_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (count[AW-1:0]),
      .wdata (in_vec),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         rd_ptr <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= CAPTURE;
                  count  <= '0;
                  rd_ptr <= '0;
               end
            end
            CAPTURE: begin
               count <= cnt_nxt;
               // The write lands first, so stop sees the post-write count.
               if (cnt_nxt == CW'(DEPTH))
                  state <= DUMP;
               else if (stop)
                  state <= (cnt_nxt != '0) ? DUMP : IDLE;
            end
            DUMP: begin
               if (out_ready) begin
                  if (last_beat) begin
                     state  <= IDLE;
                     rd_ptr <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + AW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == DUMP);
   assign out_vec   = out_valid ? rd_data : '0;
   assign out_last  = out_valid && last_beat;

endmodule
